// File: rtl/dmem_pkg.sv
// Shared types and funct3 encodings for the data-memory arbiter slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant; the port that did not win last time wins a tie.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid[0] && (!valid[1] || last_grant)) begin
      grant[0] = 1'b1;
    end else if (valid[1]) begin
      grant[1] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin sequencer for the single-port data memory:
// accept, one-cycle memory access, registered response to the winner.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [2:0]            req0_funct3,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [2:0]            req1_funct3,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  state_t                state, state_nxt;
  logic                  last_grant;
  logic [1:0]            grant;
  logic                  can_accept;
  logic                  accept0, accept1, accept;

  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [2:0]            cap_f3;
  logic                  cap_port;
  logic [DATA_WIDTH-1:0] rsp_data;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign can_accept = rst_n && ((state == IDLE) || (state == RESP));
  assign req0_ready = can_accept && grant[0];
  assign req1_ready = can_accept && grant[1];
  assign accept0    = req0_valid && req0_ready;
  assign accept1    = req1_valid && req1_ready;
  assign accept     = accept0 || accept1;

  assign mem_addr   = cap_addr;
  assign mem_wd     = cap_wdata;
  assign mem_funct3 = cap_f3;
  // rst_n gating keeps a store that is in ACCESS at a reset edge from being written.
  assign mem_we     = rst_n && (state == ACCESS) && cap_we && is_store_f3(cap_f3);

  assign rsp_data   = cap_we ? '0 : mem_rd;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = accept ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_f3     <= '0;
      cap_port   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      state      <= state_nxt;
      rsp0_valid <= (state == ACCESS) && !cap_port;
      rsp1_valid <= (state == ACCESS) && cap_port;
      if (state == ACCESS) begin
        if (cap_port) rsp1_rdata <= rsp_data;
        else          rsp0_rdata <= rsp_data;
      end
      if (accept) begin
        last_grant <= accept1;
        cap_port   <= accept1;
        cap_we     <= accept1 ? req1_we     : req0_we;
        cap_addr   <= accept1 ? req1_addr   : req0_addr;
        cap_wdata  <= accept1 ? req1_wdata  : req0_wdata;
        cap_f3     <= accept1 ? req1_funct3 : req0_funct3;
      end
    end
  end

endmodule
